// File: rtl/core_pkg.sv
// Shared core definitions: data width, the fetch FSM encoding, reset defaults
// and the canonical NOP used to fill an empty decode slot.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Clear the byte offset so any address becomes word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mux2.sv
// Generic 32-bit 2:1 mux: y = sel ? d1 : d0.
module mux2
  import core_pkg::*;
(
  input  logic            sel,
  input  logic [XLEN-1:0] d0,
  input  logic [XLEN-1:0] d1,
  output logic [XLEN-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Keeps the PC, issues one word-aligned request at a
// time to instruction memory and buffers the returned word for decode.
// Redirects from execute retarget the PC; a response that belongs to an
// abandoned request is swallowed in DROP.
//
// Handshakes:
//   imem: a request transfers on a cycle with imem_req && imem_gnt; exactly one
//         imem_rvalid follows each grant, at least one cycle later.
//   id:   an instruction transfers on a cycle with id_valid && id_ready;
//         id_pc / id_instr hold steady while id_valid && !id_ready.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);

  // FSM state kept as a named signal so checkers can bind to it directly.
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_next;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;

  // Sequential PC increment wraps modulo 2^32; redirect target is word aligned.
  assign pc_inc          = pc_q + 32'd4;
  assign redirect_target = align_word(redirect_pc);

  mux2 u_next_pc_mux (
    .sel (redirect_valid),
    .d0  (pc_inc),
    .d1  (redirect_target),
    .y   (pc_next)
  );

  // Request is a pure decode of state; forced low while reset is asserted.
  assign imem_req  = (state_q == REQ) && !rst;
  assign imem_addr = pc_q;

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;

  // Next-state, next-PC and decode-buffer update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    unique case (state_q)
      REQ: begin
        if (redirect_valid) begin
          pc_d    = pc_next;
          state_d = imem_gnt ? DROP : REQ;
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          pc_d = pc_next;
          if (redirect_valid) begin
            state_d = REQ;
          end else begin
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_instr_d = imem_rdata;
            state_d    = HOLD;
          end
        end else if (redirect_valid) begin
          pc_d    = pc_next;
          state_d = DROP;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          pc_d = pc_next;
        end
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d       = pc_next;
          id_valid_d = 1'b0;
          state_d    = REQ;
        end else if (id_ready) begin
          id_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // State, PC and decode buffer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= align_word(RESET_PC);
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A single scripted process drives every input
// on the falling edge and samples outputs there, one clock cycle per step().
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // memory model state
  logic        pend = 1'b0;
  int          cnt  = 0;
  int          lat  = 0;
  logic [31:0] paddr = '0;
  logic [31:0] req_q[$];
  logic [31:0] exp_q[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive memory inputs for the current cycle, then advance one clock.
  task automatic step();
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_data(paddr);
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req) begin
        imem_gnt = 1'b1;
        req_q.push_back(imem_addr);
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = lat;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    int          req_before;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_id_pc",    id_pc,    32'h0);
    check("rst_id_instr", id_instr, NOP);

    // reset release, zero-wait memory, decode always ready
    rst = 1'b0;
    cyc = 1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    #1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    for (int c = 1; c <= 9; c++) begin
      if (c % 3 == 1) check("seq_addr", imem_addr, 32'h100 + 32'((c - 1) / 3 * 4));
      check("seq_id_valid", {31'b0, id_valid}, (c % 3 == 0) ? 32'd1 : 32'd0);
      if (c % 3 == 0) begin
        check("seq_id_pc",    id_pc,    32'h100 + 32'((c / 3 - 1) * 4));
        check("seq_id_instr", id_instr, mem_data(32'h100 + 32'((c / 3 - 1) * 4)));
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      check("seq_req_log", req_q.pop_front(), exp_q.pop_front());
    end

    // backpressure: cycle 10 REQ(0x10c), 11 WAIT, 12 HOLD
    check("bp_addr", imem_addr, 32'h10c);
    step();
    step();
    check("bp_valid", {31'b0, id_valid}, 32'd1);
    id_ready   = 1'b0;
    hold_pc    = 32'h10c;
    hold_instr = mem_data(32'h10c);
    req_before = req_q.size();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", {31'b0, id_valid}, 32'd1);
      check("bp_hold_pc",    id_pc,    hold_pc);
      check("bp_hold_instr", id_instr, hold_instr);
      check("bp_no_req",     {31'b0, imem_req}, 32'd0);
      step();
    end
    check("bp_req_count", 32'(req_q.size()), 32'(req_before));
    id_ready = 1'b1;
    step();
    check("bp_done_valid", {31'b0, id_valid}, 32'd0);
    check("bp_next_req",   {31'b0, imem_req}, 32'd1);
    check("bp_next_addr",  imem_addr, 32'h110);

    // redirect in WAIT, response 3 cycles late
    lat = 3;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2003;
    step();
    redirect_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      check("drop_no_req",   {31'b0, imem_req}, 32'd0);
      check("drop_no_valid", {31'b0, id_valid}, 32'd0);
      step();
    end
    check("redir_req",  {31'b0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h2000);
    step();
    check("redir_wait_valid", {31'b0, id_valid}, 32'd0);
    step();
    check("redir_id_pc",    id_pc,    32'h2000);
    check("redir_id_instr", id_instr, mem_data(32'h2000));
    step();

    // redirect in the same cycle as the grant
    check("gnt_redir_addr0", imem_addr, 32'h2004);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    step();
    redirect_valid = 1'b0;
    check("gnt_redir_drop_req", {31'b0, imem_req}, 32'd0);
    step();
    check("gnt_redir_valid", {31'b0, id_valid}, 32'd0);
    check("gnt_redir_req",   {31'b0, imem_req}, 32'd1);
    check("gnt_redir_addr",  imem_addr, 32'h3000);
    step();
    step();
    check("gnt_redir_id_pc",    id_pc,    32'h3000);
    check("gnt_redir_id_instr", id_instr, mem_data(32'h3000));

    // redirect from HOLD to the top word, then wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("hold_redir_valid", {31'b0, id_valid}, 32'd0);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // asynchronous reset while holding an instruction
    step();
    step();
    check("pre_rst_valid", {31'b0, id_valid}, 32'd1);
    id_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, id_valid}, 32'd0);
    check("async_rst_instr", id_instr, NOP);
    check("async_rst_pc",    id_pc,    32'h0);
    check("async_rst_req",   {31'b0, imem_req}, 32'd0);
    step();
    rst = 1'b0;
    id_ready = 1'b1;
    #1;
    check("restart_req",  {31'b0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h100);
    step();
    step();
    check("restart_id_pc",    id_pc,    32'h100);
    check("restart_id_instr", id_instr, mem_data(32'h100));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
